mdu_sequencer: RTL and testbench
================================

// Module: mdu_sequencer
// PURPOSE
//  - Iterative multiply/divide unit for the MIPS core. One shift-add / shift-subtract step per cycle on an internal add/sub datapath.
//  - Results go to HI/LO. Sits beside the main ALU in EX.
//  - busy drives the hazard unit's stall for mult/div/mfhi/mflo.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are WIDTH bits each
// PORTS
//  clk       in   1      system clock, rising edge
//  reset     in   1      asynchronous, active-high reset
//  start     in   1      launch op; sampled only in IDLE
//  md_op     in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  a         in   WIDTH  multiplicand / dividend (rs)
//  b         in   WIDTH  multiplier / divisor (rt)
//  busy      out  1      op in flight (PREP..FIX)
//  done      out  1      one-cycle pulse; hi/lo hold the new result
//  hi        out  WIDTH  HI register (product high half / remainder)
//  lo        out  WIDTH  LO register (product low half / quotient)
//  hilo_we   in   2      [1] write HI, [0] write LO   (MDU_HILO_WRITE_EN only)
//  hilo_wdata in  WIDTH  mthi/mtlo data              (MDU_HILO_WRITE_EN only)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, busy=0, done=0, hi=0, lo=0; in-flight op discarded.
//  - FSM: IDLE -> PREP -> ITER (WIDTH cycles, counter WIDTH-1..0) -> FIX -> IDLE.
//  - IDLE: start=1 at edge N latches a, b, md_op and enters PREP.
//  - busy=1 at edges N+1 .. N+WIDTH+2; done=1 for exactly one cycle after edge N+WIDTH+2.
//  - Fixed latency WIDTH+2 edges, no early termination.
//  - PREP: for signed ops, take magnitudes |a| and |b| as unsigned WIDTH-bit values (|0x80000000| = 0x80000000).
//    Record sign_q = a[W-1]^b[W-1] and sign_r = a[W-1].
//  - ITER, multiply: {acc,mq} shift right by 1; add multiplicand when mq[0]=1; 2*WIDTH-bit product.
//  - ITER, divide: restoring; shift {rem,q} left by 1, trial rem-divisor.
//    Keep the difference and set q bit when it does not borrow.
//  - FIX, MULT: negate the 2W product when sign_q=1.
//  - FIX, DIV: negate quotient when sign_q=1; negate remainder when sign_r=1.
//  - FIX writes hi/lo.
//  - Divide by zero (b=0), DIVU/DIV: hi=a (original), lo={WIDTH{1'b1}}; same latency, no exception.
//  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; wraps, no trap.
//  - start while busy or in FIX: ignored. No queueing. Operands are not re-sampled mid-op.
//  - hi/lo hold their value between ops. Registers change only in FIX, on reset, or on a HILO write.
// CONFIGURATION
//  - Macro MDU_HILO_WRITE_EN.
//  - Defined: hilo_we/hilo_wdata exist. In IDLE with start=0, hilo_we[1] loads hi and hilo_we[0] loads lo at the edge.
//    Both bits may be set together.
//    With start=1 in the same cycle, start wins and the write is dropped.
//    While busy the write is dropped; the hazard unit stalls mthi/mtlo on busy.
//  - Undefined: the ports are absent; hi/lo are written only by FIX and reset.
// STRUCTURE
//  - Shared package/header mdu_defs: md_op encodings (MD_MULTU..MD_DIV), FSM state codes
//    (S_IDLE, S_PREP, S_ITER, S_FIX), add/sub select codes matching the main ALU (ADD=3'b000, SUB=3'b001).
//  - One sub-module mdu_addsub: combinational WIDTH+1-bit add/sub with carry/borrow out,
//    shared by multiply and divide steps.
//  - Top: FSM, iteration counter, operand/accumulator registers, sign fix-up.
// TESTING
//  1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start @N -> done after edge N+34; hi=0xFFFFFFFE lo=0x00000001; busy high 34 cycles.
//  2. MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//  3. DIVU a=100 b=0 -> hi=100 lo=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
//  4. Second start with different operands at N+5 (while busy) -> ignored; result is from the first op; single done pulse.
//  5. reset asserted mid-ITER (N+10, between edges) -> busy/done/hi/lo=0 immediately.
//     start after release -> full WIDTH+2 latency.
//  6. MDU_HILO_WRITE_EN: hilo_we=2'b11 wdata=0x1234 in IDLE -> hi=lo=0x1234.
//     hilo_we=2'b01 with start=1 -> write dropped; op result lands. Write while busy -> dropped.

Source files
------------

// File: rtl/mdu_defs_pkg.sv
// mdu_defs: shared definitions for the iterative multiply/divide unit.
//   md_op encodings, sequencer state codes and add/sub select codes
//   (same codes as the main ALU).
package mdu_defs;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_ITER = 2'b10,
    S_FIX  = 2'b11
  } state_e;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mdu_addsub.sv
// mdu_addsub: combinational W-bit adder/subtractor shared by the multiply
// (add) and divide (trial subtract) steps.
//   x, y  : operands
//   op    : ADD or SUB select code
//   res   : x+y or x-y, W bits
//   cout  : carry out; for SUB, 1 means no borrow (x >= y)
module mdu_addsub
  import mdu_defs::*;
#(
  parameter int W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [2:0]   op,
  output logic [W-1:0] res,
  output logic         cout
);

  logic [W:0] full;

  always_comb begin
    if (op == SUB) full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else           full = {1'b0, x} + {1'b0, y};
  end

  assign res  = full[W-1:0];
  assign cout = full[W];

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative multiply/divide unit, one shift-add or
// shift-subtract step per cycle, results written to HI/LO.
//   clk, reset        : clock, async active-high reset
//   start, md_op      : launch op (sampled only in IDLE), op select
//   a, b              : rs / rt operands
//   busy              : op in flight (PREP..FIX), feeds the stall logic
//   done              : one-cycle pulse once hi/lo hold the new result
//   hi, lo            : HI / LO registers
//   hilo_we,hilo_wdata: mthi/mtlo write port, present only when the
//                       macro MDU_HILO_WRITE_EN is defined
module mdu_sequencer
  import mdu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MDU_HILO_WRITE_EN
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  md_op_e           op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;     // product high half / partial remainder
  logic [WIDTH-1:0] mq_q;      // multiplier / quotient; raw a until PREP
  logic [WIDTH-1:0] mcand_q;   // multiplicand / divisor; raw b until PREP
  logic             sign_q_q;  // negate product or quotient in FIX
  logic             sign_r_q;  // negate remainder in FIX
  logic             b_zero_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             is_div;
  logic [WIDTH:0]   as_x, as_y, as_res;
  logic             as_cout;
  logic [2:0]       as_op;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] hi_fix, lo_fix;
  logic [2*WIDTH-1:0] prod, prod_neg;

  assign is_div = op_is_div(op_q);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_PREP;
      S_PREP: state_d = S_ITER;
      S_ITER: if (cnt_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Magnitudes of the raw operands latched in IDLE; |min| wraps to itself.
  always_comb begin
    mag_a = (op_is_signed(op_q) && mq_q[WIDTH-1])    ? -mq_q    : mq_q;
    mag_b = (op_is_signed(op_q) && mcand_q[WIDTH-1]) ? -mcand_q : mcand_q;
  end

  // Divide: trial subtract of the divisor from the left-shifted remainder.
  // Multiply: add multiplicand (or zero) to acc; bit WIDTH is the carry.
  always_comb begin
    if (is_div) begin
      as_op = SUB;
      as_x  = {acc_q, mq_q[WIDTH-1]};
      as_y  = {1'b0, mcand_q};
    end else begin
      as_op = ADD;
      as_x  = {1'b0, acc_q};
      as_y  = {1'b0, (mq_q[0] ? mcand_q : '0)};
    end
  end

  mdu_addsub #(.W(WIDTH + 1)) u_addsub (
    .x    (as_x),
    .y    (as_y),
    .op   (as_op),
    .res  (as_res),
    .cout (as_cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= MD_MULTU;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      mcand_q  <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      b_zero_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == S_FIX);
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= md_op_e'(md_op);
            mq_q    <= a;
            mcand_q <= b;
          end
        end
        S_PREP: begin
          sign_q_q <= op_is_signed(op_q) & (mq_q[WIDTH-1] ^ mcand_q[WIDTH-1]);
          sign_r_q <= op_is_signed(op_q) & mq_q[WIDTH-1];
          b_zero_q <= (mcand_q == '0);
          acc_q    <= '0;
          cnt_q    <= CW'(WIDTH - 1);
          if (is_div) begin
            mcand_q <= mag_b;
            mq_q    <= mag_a;
          end else begin
            mcand_q <= mag_a;
            mq_q    <= mag_b;
          end
        end
        S_ITER: begin
          cnt_q <= cnt_q - 1'b1;
          if (is_div) begin
            acc_q <= as_cout ? as_res[WIDTH-1:0] : {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
            mq_q  <= {mq_q[WIDTH-2:0], as_cout};
          end else begin
            acc_q <= as_res[WIDTH:1];
            mq_q  <= {as_res[0], mq_q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Sign fix-up. With a zero divisor the restoring loop leaves rem=|a| and
  // all-ones quotient, so the remainder path already yields the original a.
  always_comb begin
    prod     = {acc_q, mq_q};
    prod_neg = -prod;
    if (is_div) begin
      hi_fix = sign_r_q ? -acc_q : acc_q;
      lo_fix = b_zero_q ? '1 : (sign_q_q ? -mq_q : mq_q);
    end else begin
      {hi_fix, lo_fix} = sign_q_q ? prod_neg : prod;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == S_FIX) begin
      hi_q <= hi_fix;
      lo_q <= lo_fix;
    end
`ifdef MDU_HILO_WRITE_EN
    else if (state_q == S_IDLE && !start) begin
      if (hilo_we[1]) hi_q <= hilo_wdata;
      if (hilo_we[0]) lo_q <= hilo_wdata;
    end
`endif
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   md_op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;
`ifdef MDU_HILO_WRITE_EN
  logic [1:0]   hilo_we = 2'b00;
  logic [W-1:0] hilo_wdata = '0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .md_op      (md_op),
    .a          (a),
    .b          (b),
`ifdef MDU_HILO_WRITE_EN
    .hilo_we    (hilo_we),
    .hilo_wdata (hilo_wdata),
`endif
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive start at the negedge before edge N, release 1 ns after edge N.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start = 1'b1; md_op = op; a = av; b = bv;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // mode 0: plain; 1: second start at N+5; 2: hilo write at N+5 (pre = hi/lo before op)
  task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input int mode, input logic [63:0] pre);
    int lat = 0;
    int busy_cnt = 0;
    int pulses = 0;
    launch(op, av, bv);
    if (busy) busy_cnt++;
    for (int k = 1; k <= W + 10; k++) begin
      if (k == 5 && mode == 1) begin
        @(negedge clk);
        start = 1'b1; md_op = 2'b10; a = 32'd1000; b = 32'd3;
      end
`ifdef MDU_HILO_WRITE_EN
      if (k == 5 && mode == 2) begin
        @(negedge clk);
        hilo_we = 2'b11; hilo_wdata = 32'h0000BEEF;
      end
`endif
      @(posedge clk);
      #1;
      start = 1'b0;
`ifdef MDU_HILO_WRITE_EN
      if (k == 5 && mode == 2) begin
        hilo_we = 2'b00;
        chk({tag, "_busy_write"}, {hi, lo}, pre);
      end
`endif
      if (busy) busy_cnt++;
      if (done) begin
        pulses++;
        if (lat == 0) lat = k;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(W + 2));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 2));
    chk({tag, "_done_pulses"}, 64'(pulses), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 64'd0);

    // Async reset between edges mid-ITER.
    launch(2'b00, 32'h0000FFFF, 32'h0000FFFF);
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op("post_rst", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 0, 64'd0);

    do_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 64'd0);
    do_op("mult_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 64'd0);
    do_op("multu_sh", 2'b00, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 0, 64'd0);
    do_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 64'd0);
    do_op("div_negb", 2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 0, 64'd0);
    do_op("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 0, 64'd0);
    do_op("divu_zero", 2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 0, 64'd0);
    do_op("div_zero", 2'b11, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 0, 64'd0);
    do_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 64'd0);
    do_op("restart_ign", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1, 64'd0);

`ifdef MDU_HILO_WRITE_EN
    @(negedge clk);
    hilo_we = 2'b11; hilo_wdata = 32'h00001234;
    @(posedge clk);
    #1 hilo_we = 2'b00;
    chk("hilo_wr_hi", 64'(hi), 64'h1234);
    chk("hilo_wr_lo", 64'(lo), 64'h1234);

    @(negedge clk);
    hilo_we = 2'b01; hilo_wdata = 32'h0000DEAD;
    start = 1'b1; md_op = 2'b00; a = 32'd2; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0; hilo_we = 2'b00;
    chk("hilo_start_lo", 64'(lo), 64'h1234);
    repeat (W + 2) @(posedge clk);
    #1;
    chk("hilo_start_done", 64'(done), 64'd1);
    chk("hilo_start_res", {hi, lo}, 64'd6);

    do_op("hilo_busy", 2'b00, 32'd9, 32'd9, 32'd0, 32'd81, 2, 64'd6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
